// File: rtl/design_select_ctrl_if.sv
// Bundle for the design-select controller: serial command pins in, mux/chip-select
// controls out. The controller takes the slave side; the command source takes master.
interface design_select_ctrl_if #(
  parameter int unsigned NUM_DESIGNS = 12
);
  logic                   cmd_ncs;
  logic                   cmd_sck;
  logic                   cmd_sdi;
  logic [3:0]             design_select;
  logic [NUM_DESIGNS-1:0] design_ncs;
  logic                   force_input;
  logic                   busy;
  logic                   err;

  modport master (
    output cmd_ncs, cmd_sck, cmd_sdi,
    input  design_select, design_ncs, force_input, busy, err
  );

  modport slave (
    input  cmd_ncs, cmd_sck, cmd_sdi,
    output design_select, design_ncs, force_input, busy, err
  );
endinterface

// File: rtl/design_select_ctrl.sv
// Serial-commanded design selector. Every switch runs break-before-make:
// deselect all and force pads to input, guard, change the mux, settle, then enable.
module design_select_ctrl #(
  parameter int unsigned NUM_DESIGNS   = 12,
  parameter int unsigned GUARD_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  design_select_ctrl_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrain  = 3'd1;
  localparam logic [2:0] StSwitch = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StEnable = 3'd4;

  logic [1:0] ncs_sync_q, sck_sync_q, sdi_sync_q;
  logic       ncs_prev_q, sck_prev_q;
  logic       ncs_s, sck_s, sdi_s, ncs_fall, ncs_rise, sck_rise;

  logic [7:0] shift_q, shift_d;
  logic [3:0] bits_q, bits_d;
  logic [2:0] state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [3:0] target_q, target_d;
  logic [3:0] sel_q, sel_d;
  logic [NUM_DESIGNS-1:0] ncs_q, ncs_d, ncs_dec;
  logic       force_q, force_d, busy_q, busy_d, err_q, err_d;
  logic       start;
  logic [3:0] opc, cmd_id;

  assign ncs_s    = ncs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign ncs_fall = ~ncs_s & ncs_prev_q;
  assign ncs_rise = ncs_s & ~ncs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign opc      = shift_q[7:4];
  assign cmd_id   = shift_q[3:0];

  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    if (ncs_fall) begin
      bits_d = '0;
    end else if (sck_rise && !ncs_s) begin
      shift_d = {shift_q[6:0], sdi_s};
      if (bits_q != 4'd9) bits_d = bits_q + 4'd1;
    end
  end

  // Frame evaluation; busy_q also covers the ENABLE cycle, so a coincident frame is dropped.
  always_comb begin
    start = 1'b0;
    err_d = err_q;
    if (ncs_rise) begin
      if (bits_q != 4'd8) begin
        err_d = 1'b1;
      end else if (opc == 4'h5) begin
        err_d = 1'b0;
      end else if (opc == 4'hA) begin
        if (busy_q || (32'(cmd_id) > NUM_DESIGNS)) begin
          err_d = 1'b1;
        end else if (!((cmd_id == sel_q) && (cmd_id != 4'd0))) begin
          start = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrain;
          tmr_d    = 8'(GUARD_CYCLES - 1);
          target_d = cmd_id;
        end
      end
      StDrain: begin
        if (tmr_q == 8'd0) state_d = StSwitch;
        else               tmr_d   = tmr_q - 8'd1;
      end
      StSwitch: begin
        tmr_d   = 8'(SETTLE_CYCLES - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (tmr_q == 8'd0) state_d = StEnable;
        else               tmr_d   = tmr_q - 8'd1;
      end
      StEnable: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ncs_dec = '1;
    for (int i = 0; i < int'(NUM_DESIGNS); i++) begin
      if (target_q == 4'(i + 1)) ncs_dec[i] = 1'b0;
    end
  end

  // Outputs are loaded on the edge entering the state that owns them.
  always_comb begin
    sel_d   = sel_q;
    ncs_d   = ncs_q;
    force_d = force_q;
    if (state_q == StIdle && start) begin
      ncs_d   = '1;
      force_d = 1'b1;
    end
    if (state_q == StDrain && tmr_q == 8'd0) sel_d = target_q;
    if (state_q == StSettle && tmr_q == 8'd0) begin
      ncs_d   = ncs_dec;
      force_d = (target_q == 4'd0);
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ncs_sync_q <= 2'b11;
      sck_sync_q <= 2'b00;
      sdi_sync_q <= 2'b00;
      ncs_prev_q <= 1'b1;
      sck_prev_q <= 1'b0;
      shift_q    <= '0;
      bits_q     <= '0;
      state_q    <= StIdle;
      tmr_q      <= '0;
      target_q   <= '0;
      sel_q      <= '0;
      ncs_q      <= '1;
      force_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ncs_sync_q <= {ncs_sync_q[0], bus.cmd_ncs};
      sck_sync_q <= {sck_sync_q[0], bus.cmd_sck};
      sdi_sync_q <= {sdi_sync_q[0], bus.cmd_sdi};
      ncs_prev_q <= ncs_s;
      sck_prev_q <= sck_s;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      target_q   <= target_d;
      sel_q      <= sel_d;
      ncs_q      <= ncs_d;
      force_q    <= force_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.design_select = sel_q;
  assign bus.design_ncs    = ncs_q;
  assign bus.force_input   = force_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed bench for design_select_ctrl: switch timing, overlap freedom, bad frames,
// busy rejection (on a long-settle instance) and reset during a switch.
module tb_design_select_ctrl;
  localparam int unsigned G  = 4;
  localparam int unsigned S  = 16;
  localparam int unsigned S2 = 200;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic ncs_r = 1'b1, sck_r = 1'b0, sdi_r = 1'b0;
  logic use2 = 1'b0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  design_select_ctrl_if #(.NUM_DESIGNS(12)) bus  ();
  design_select_ctrl_if #(.NUM_DESIGNS(12)) bus2 ();

  assign bus.cmd_ncs  = use2 ? 1'b1 : ncs_r;
  assign bus.cmd_sck  = sck_r;
  assign bus.cmd_sdi  = sdi_r;
  assign bus2.cmd_ncs = use2 ? ncs_r : 1'b1;
  assign bus2.cmd_sck = sck_r;
  assign bus2.cmd_sdi = sdi_r;

  design_select_ctrl #(.NUM_DESIGNS(12), .GUARD_CYCLES(G), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  design_select_ctrl #(.NUM_DESIGNS(12), .GUARD_CYCLES(G), .SETTLE_CYCLES(S2)) dut2 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus2.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_ncs(input logic [3:0] id);
    logic [11:0] one;
    one = 12'd1;
    if (id == 4'd0) return 12'hFFF;
    return ~(one << (id - 4'd1));
  endfunction

  // Sends the top nbits of b, MSB first, with 4-cycle sck phases.
  task automatic send_frame(input logic [7:0] b, input int nbits);
    @(negedge clk);
    ncs_r = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi_r = b[7-i];
      repeat (4) @(negedge clk);
      sck_r = 1'b1;
      repeat (4) @(negedge clk);
      sck_r = 1'b0;
    end
    repeat (4) @(negedge clk);
    ncs_r = 1'b1;
  endtask

  task automatic wait_busy(input logic which2, output logic seen);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if ((which2 ? bus2.busy : bus.busy) === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_switch(input logic [3:0] id, input logic [3:0] old_sel);
    logic seen;
    send_frame({4'hA, id}, 8);
    wait_busy(1'b0, seen);
    check_eq("busy_rise", 32'(seen), 1);
    if (!seen) return;
    for (int k = 0; k <= int'(G + S + 2); k++) begin
      if (k > 0) @(negedge clk);
      check_eq("no_overlap", 32'($countones(~bus.design_ncs) <= 1), 1);
      check_eq("fi_match", 32'(bus.force_input || (bus.design_ncs == exp_ncs(bus.design_select))), 1);
      if (k == 0) begin
        check_eq("drain_ncs", 32'(bus.design_ncs), 32'h0FFF);
        check_eq("drain_fi", 32'(bus.force_input), 1);
        check_eq("drain_sel", 32'(bus.design_select), 32'(old_sel));
      end
      if (k == int'(G) - 1) check_eq("sel_hold", 32'(bus.design_select), 32'(old_sel));
      if (k == int'(G))     check_eq("sel_new", 32'(bus.design_select), 32'(id));
      if (k == int'(G + S)) check_eq("ncs_pre", 32'(bus.design_ncs), 32'h0FFF);
      if (k == int'(G + S + 1)) begin
        check_eq("ncs_en", 32'(bus.design_ncs), 32'(exp_ncs(id)));
        check_eq("fi_en", 32'(bus.force_input), 32'(id == 4'd0));
        check_eq("busy_en", 32'(bus.busy), 1);
      end
      if (k == int'(G + S + 2)) check_eq("busy_fall", 32'(bus.busy), 0);
    end
  endtask

  task automatic frame_then_settle(input logic [7:0] b, input int nbits);
    send_frame(b, nbits);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_sel", 32'(bus.design_select), 0);
    check_eq("rst_ncs", 32'(bus.design_ncs), 32'h0FFF);
    check_eq("rst_fi", 32'(bus.force_input), 1);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_err", 32'(bus.err), 0);

    run_switch(4'd3, 4'd0);
    run_switch(4'd7, 4'd3);

    frame_then_settle(8'hAD, 8);
    check_eq("id13_err", 32'(bus.err), 1);
    check_eq("id13_sel", 32'(bus.design_select), 7);
    check_eq("id13_ncs", 32'(bus.design_ncs), 32'h0FBF);
    check_eq("id13_busy", 32'(bus.busy), 0);
    frame_then_settle(8'h50, 8);
    check_eq("clr_err", 32'(bus.err), 0);
    frame_then_settle(8'hA4, 7);
    check_eq("short_err", 32'(bus.err), 1);
    check_eq("short_sel", 32'(bus.design_select), 7);
    frame_then_settle(8'h50, 8);
    check_eq("clr_err2", 32'(bus.err), 0);
    frame_then_settle(8'h37, 8);
    check_eq("opc_err", 32'(bus.err), 1);
    frame_then_settle(8'h50, 8);

    // Reselecting the active design must not start a sequence.
    send_frame(8'hA7, 8);
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) seen = 1'b1;
    end
    check_eq("noop_busy", 32'(seen), 0);
    check_eq("noop_ncs", 32'(bus.design_ncs), 32'h0FBF);
    check_eq("noop_fi", 32'(bus.force_input), 0);
    check_eq("noop_err", 32'(bus.err), 0);

    // Long-settle instance keeps busy across a whole second frame.
    use2 = 1'b1;
    send_frame(8'hA2, 8);
    wait_busy(1'b1, seen);
    check_eq("b2_rise", 32'(seen), 1);
    frame_then_settle(8'hA5, 8);
    check_eq("b2_still", 32'(bus2.busy), 1);
    check_eq("b2_err", 32'(bus2.err), 1);
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (bus2.busy === 1'b0) seen = 1'b1;
    end
    check_eq("b2_done", 32'(seen), 1);
    check_eq("b2_sel", 32'(bus2.design_select), 2);
    check_eq("b2_ncs", 32'(bus2.design_ncs), 32'h0FFD);
    check_eq("b2_err_keep", 32'(bus2.err), 1);
    use2 = 1'b0;

    // Reset during DRAIN.
    send_frame(8'hA4, 8);
    wait_busy(1'b0, seen);
    check_eq("mid_busy", 32'(seen), 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_eq("mid_sel", 32'(bus.design_select), 0);
    check_eq("mid_ncs", 32'(bus.design_ncs), 32'h0FFF);
    check_eq("mid_fi", 32'(bus.force_input), 1);
    check_eq("mid_busy0", 32'(bus.busy), 0);
    check_eq("mid_err", 32'(bus.err), 0);
    #3;
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    run_switch(4'd1, 4'd0);
    check_eq("final_err", 32'(bus.err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
